// File: rtl/nand_unit_arbiter_pkg.sv
// Shared types for the NAND unit arbiter: FSM state encoding.
package nand_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nand_unit_arbiter_word.sv
// WIDTH-bit NAND word built from one two-input NAND cell per bit.
module nand_word #(
  parameter int unsigned WIDTH = 32
) (
  output logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nand u_nand (f[i], a[i], b[i]);
  end

endmodule

// File: rtl/nand_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one NAND word among NREQ requesters.
module nand_unit_arbiter
  import nand_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_f,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic                  busy
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, win, id_q;
  logic             win_ok, grant_en;
  logic [WIDTH-1:0] a_q, b_q, sel_a, sel_b, nand_f;

  // Rotate-priority find-first: returns {found, index}, searching ptr, ptr+1, ... mod NREQ.
  function automatic logic [IDW:0] find_first(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW:0] res;
    res = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!res[IDW] && r[(32'(p) + k) % NREQ]) begin
        res = {1'b1, IDW'((32'(p) + k) % NREQ)};
      end
    end
    return res;
  endfunction

  // Winner selection and grant qualification (gated by clrn so no grant shows during reset).
  always_comb begin
    {win_ok, win} = find_first(req, ptr);
    grant_en      = clrn && win_ok &&
                    ((state == S_IDLE) || ((state == S_DONE) && res_ready));
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = a_in[i*WIDTH +: WIDTH];
        sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  nand_word #(.WIDTH(WIDTH)) u_nand_word (
    .f (nand_f),
    .a (a_q),
    .b (b_q)
  );

  // Next-state and Mealy grant decode.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      S_IDLE: begin
        if (grant_en) begin
          gnt[win]  = 1'b1;
          state_nxt = S_EVAL;
        end
      end
      S_EVAL: state_nxt = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          if (grant_en) begin
            gnt[win]  = 1'b1;
            state_nxt = S_EVAL;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Operand latch on grant, result capture in EVAL, release on handshake.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      res_f     <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (grant_en) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= win;
        ptr  <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      end
      if (state == S_EVAL) begin
        res_f     <= nand_f;
        res_id    <= id_q;
        res_valid <= 1'b1;
      end else if ((state == S_DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Directed self-checking bench for nand_unit_arbiter (NREQ=4, WIDTH=32).
module tb_nand_unit_arbiter;

  logic         clk = 1'b0;
  logic         clrn;
  logic [3:0]   req;
  logic [127:0] a_in, b_in;
  logic [3:0]   gnt;
  logic         res_valid;
  logic [31:0]  res_f;
  logic [1:0]   res_id;
  logic         res_ready;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] tab_a [4] = '{32'hF0F0F0F0, 32'h0000FFFF, 32'hAAAAAAAA, 32'hFFFFFFFF};
  logic [31:0] tab_b [4] = '{32'hFF00FF00, 32'h00FF00FF, 32'h5555FFFF, 32'h12345678};
  logic [31:0] tab_f [4] = '{32'h0FFF0FFF, 32'hFFFFFF00, 32'hFFFF5555, 32'hEDCBA987};

  nand_unit_arbiter #(.NREQ(4), .WIDTH(32), .IDW(2)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_f     (res_f),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      a_in[i*32 +: 32] = tab_a[i];
      b_in[i*32 +: 32] = tab_b[i];
    end
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    req  = '0;
    step();
    clrn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; req = 4'b1111; res_ready = 1'b1; a_in = '1; b_in = '1;
    #2; step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", res_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (res_f !== 32'h0) $display("FAIL reset_f got %h want 0", res_f); else n_pass++;
    n_total++; if (res_id !== 2'd0) $display("FAIL reset_id got %0d want 0", res_id); else n_pass++;
    req = '0;
    clrn = 1'b1;
    step();
  endtask

  task automatic test_single_op();
    res_ready = 1'b0;
    a_in[64 +: 32] = 32'hFFFF0000;
    b_in[64 +: 32] = 32'hFF00FF00;
    req = 4'b0100;
    #1;
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_gnt got %b want 0100", gnt); else n_pass++;
    step();
    req = '0;
    #1;
    n_total++; if (res_valid !== 1'b0) $display("FAIL single_eval_valid got %b want 0", res_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_eval_busy got %b want 1", busy); else n_pass++;
    step();
    n_total++; if (res_valid !== 1'b1) $display("FAIL single_valid got %b want 1", res_valid); else n_pass++;
    n_total++; if (res_f !== 32'h00FFFFFF) $display("FAIL single_f got %h want 00ffffff", res_f); else n_pass++;
    n_total++; if (res_id !== 2'd2) $display("FAIL single_id got %0d want 2", res_id); else n_pass++;
  endtask

  task automatic test_backpressure();
    load_table();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++; if (gnt !== 4'b0000) $display("FAIL bp_gnt[%0d] got %b want 0000", c, gnt); else n_pass++;
      n_total++; if (res_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", c, res_valid); else n_pass++;
      n_total++; if (res_f !== 32'h00FFFFFF) $display("FAIL bp_f[%0d] got %h want 00ffffff", c, res_f); else n_pass++;
      n_total++; if (res_id !== 2'd2) $display("FAIL bp_id[%0d] got %0d want 2", c, res_id); else n_pass++;
      step();
    end
    res_ready = 1'b1;
    #1;
    n_total++; if (gnt !== 4'b1000) $display("FAIL bp_release_gnt got %b want 1000", gnt); else n_pass++;
    step();
    n_total++; if (res_valid !== 1'b0) $display("FAIL bp_eval_valid got %b want 0", res_valid); else n_pass++;
    step();
    n_total++; if (res_id !== 2'd3) $display("FAIL bp_next_id got %0d want 3", res_id); else n_pass++;
    n_total++; if (res_f !== 32'hEDCBA987) $display("FAIL bp_next_f got %h want edcba987", res_f); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_gnt;
    do_reset();
    load_table();
    res_ready = 1'b1;
    req = 4'b1111;
    #1;
    n_total++; if (gnt !== 4'b0001) $display("FAIL rr_first_gnt got %b want 0001", gnt); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      step();
      n_total++; if (res_valid !== 1'b0) $display("FAIL rr_eval_valid[%0d] got %b want 0", k, res_valid); else n_pass++;
      step();
      want_gnt = 4'b0001 << ((k + 1) % 4);
      n_total++; if (res_valid !== 1'b1) $display("FAIL rr_valid[%0d] got %b want 1", k, res_valid); else n_pass++;
      n_total++; if (res_id !== 2'(k % 4)) $display("FAIL rr_id[%0d] got %0d want %0d", k, res_id, k % 4); else n_pass++;
      n_total++; if (res_f !== tab_f[k % 4]) $display("FAIL rr_f[%0d] got %h want %h", k, res_f, tab_f[k % 4]); else n_pass++;
      n_total++; if (gnt !== want_gnt) $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, want_gnt); else n_pass++;
    end
    req = '0;
    res_ready = 1'b0;
  endtask

  task automatic test_ptr_skip();
    do_reset();
    load_table();
    res_ready = 1'b1;
    req = 4'b0100;
    #1;
    n_total++; if (gnt !== 4'b0100) $display("FAIL skip_first_gnt got %b want 0100", gnt); else n_pass++;
    step();
    req = 4'b0011;
    #1;
    n_total++; if (gnt !== 4'b0000) $display("FAIL skip_eval_gnt got %b want 0000", gnt); else n_pass++;
    step();
    n_total++; if (res_id !== 2'd2) $display("FAIL skip_id2 got %0d want 2", res_id); else n_pass++;
    n_total++; if (gnt !== 4'b0001) $display("FAIL skip_wrap_gnt got %b want 0001", gnt); else n_pass++;
    step();
    step();
    n_total++; if (res_id !== 2'd0) $display("FAIL skip_id0 got %0d want 0", res_id); else n_pass++;
    n_total++; if (gnt !== 4'b0010) $display("FAIL skip_next_gnt got %b want 0010", gnt); else n_pass++;
    step();
    req = '0;
    step();
    n_total++; if (res_id !== 2'd1) $display("FAIL skip_id1 got %0d want 1", res_id); else n_pass++;
    n_total++; if (res_f !== 32'hFFFFFF00) $display("FAIL skip_f1 got %h want ffffff00", res_f); else n_pass++;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL skip_idle_busy got %b want 0", busy); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL skip_idle_valid got %b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_mid_reset();
    res_ready = 1'b1;
    req = 4'b0010;
    #1;
    n_total++; if (gnt !== 4'b0010) $display("FAIL mid_gnt got %b want 0010", gnt); else n_pass++;
    step();
    req = '0;
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_eval_busy got %b want 1", busy); else n_pass++;
    clrn = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_clr_busy got %b want 0", busy); else n_pass++;
    clrn = 1'b1;
    step();
    n_total++; if (res_valid !== 1'b0) $display("FAIL mid_after_valid got %b want 0", res_valid); else n_pass++;
    step();
    n_total++; if (res_valid !== 1'b0) $display("FAIL mid_after2_valid got %b want 0", res_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_after_busy got %b want 0", busy); else n_pass++;
    req = 4'b0110;
    #1;
    n_total++; if (gnt !== 4'b0010) $display("FAIL mid_regrant_gnt got %b want 0010", gnt); else n_pass++;
    step();
    req = '0;
    step();
    n_total++; if (res_id !== 2'd1) $display("FAIL mid_regrant_id got %0d want 1", res_id); else n_pass++;
    n_total++; if (res_valid !== 1'b1) $display("FAIL mid_regrant_valid got %b want 1", res_valid); else n_pass++;
    step();
  endtask

  initial begin
    clrn = 1'b0; req = '0; res_ready = 1'b0; a_in = '0; b_in = '0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_back_to_back();
    test_ptr_skip();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
